// File: rtl/pll_freq_monitor.sv
// PLL frequency monitor: counts rising edges of meas_in over a fixed gate
// window of inclk0 cycles, reports the count, flags an in-band result and
// asserts locked after a run of consecutive good windows.
module pll_freq_monitor #(
    parameter int GATE_CYCLES  = 50000,
    parameter int CNT_W        = 16,
    parameter int EXP_MIN      = 24000,
    parameter int EXP_MAX      = 26000,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic             inclk0,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             meas_in,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             in_range,
    output logic             overflow,
    output logic             locked
);
    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int STRK_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
    localparam logic [STRK_W-1:0] STRK_FULL = STRK_W'(LOCK_WINDOWS);
    // Band limits held wider than the counter so EXP_MAX >= 2^CNT_W stays exact.
    localparam logic [32:0] MIN_X = 33'(EXP_MIN);
    localparam logic [32:0] MAX_X = 33'(EXP_MAX);

    typedef enum logic [1:0] {IDLE, GATE, REPORT} state_t;

    state_t              state, state_nxt;
    logic                s1, s2, s3;
    logic                rise;
    logic [GATE_W-1:0]   gate_cnt;
    logic [CNT_W-1:0]    edge_cnt;
    logic                ovf_r;
    logic [STRK_W-1:0]   streak, streak_inc;
    logic                start_win;
    logic                win_in_range;
    logic [32:0]         edge_x;

    assign rise         = s2 & ~s3;
    assign edge_x       = 33'(edge_cnt);
    assign win_in_range = !ovf_r && (edge_x >= MIN_X) && (edge_x <= MAX_X);
    assign streak_inc   = (streak == STRK_FULL) ? streak : streak + 1'b1;

    // Two-flop synchronizer plus a delay flop for rising-edge detection.
    always_ff @(posedge inclk0) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= meas_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // State register.
    always_ff @(posedge inclk0) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; start_win marks every entry into a fresh gate window.
    always_comb begin
        state_nxt = state;
        start_win = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = GATE;
                    start_win = 1'b1;
                end
            end
            GATE: begin
                if (!enable)                    state_nxt = IDLE;
                else if (gate_cnt == GATE_LAST) state_nxt = REPORT;
            end
            REPORT: begin
                if (enable) begin
                    state_nxt = GATE;
                    start_win = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Window counters, report registers and lock streak.
    always_ff @(posedge inclk0) begin
        if (!rst_n) begin
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf_r       <= 1'b0;
            streak      <= '0;
            count       <= '0;
            count_valid <= 1'b0;
            in_range    <= 1'b0;
            overflow    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (state == GATE) begin
                if (!enable) begin
                    // Aborted window: no report, but the good-window run is broken.
                    streak <= '0;
                    locked <= 1'b0;
                end else begin
                    gate_cnt <= gate_cnt + 1'b1;
                    if (rise) begin
                        if (edge_cnt == CNT_SAT) ovf_r    <= 1'b1;
                        else                     edge_cnt <= edge_cnt + 1'b1;
                    end
                end
            end
            if (state == REPORT) begin
                count       <= edge_cnt;
                overflow    <= ovf_r;
                count_valid <= 1'b1;
                in_range    <= win_in_range;
                if (win_in_range) begin
                    streak <= streak_inc;
                    locked <= (streak_inc == STRK_FULL);
                end else begin
                    streak <= '0;
                    locked <= 1'b0;
                end
            end
            if (start_win) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ovf_r    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pll_freq_monitor.sv
// Bench for pll_freq_monitor: window-level reference model fed from a history
// of synchronised meas_in samples, table-driven patterns, random patterns and
// hand-written abort/reset sequences. A CNT_W=4 copy covers saturation.
module tb_pll_freq_monitor;
    localparam int GATE_N = 100;
    localparam int PERIOD = GATE_N + 1;
    localparam int LOCKW  = 3;
    localparam int EMIN   = 24;
    localparam int EMAX   = 26;
    localparam int HMAX   = 65536;

    logic       inclk0 = 1'b0;
    logic       rst_n, enable, meas_in;
    logic [7:0] count;
    logic       count_valid, in_range, overflow, locked;
    logic [3:0] count4;
    logic       count_valid4, in_range4, overflow4, locked4;

    pll_freq_monitor #(.GATE_CYCLES(GATE_N), .CNT_W(8), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
                       .LOCK_WINDOWS(LOCKW)) dut (
        .inclk0(inclk0), .rst_n(rst_n), .enable(enable), .meas_in(meas_in),
        .count(count), .count_valid(count_valid), .in_range(in_range),
        .overflow(overflow), .locked(locked));

    pll_freq_monitor #(.GATE_CYCLES(GATE_N), .CNT_W(4), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
                       .LOCK_WINDOWS(LOCKW)) dut4 (
        .inclk0(inclk0), .rst_n(rst_n), .enable(enable), .meas_in(meas_in),
        .count(count4), .count_valid(count_valid4), .in_range(in_range4),
        .overflow(overflow4), .locked(locked4));

    always #5 inclk0 = ~inclk0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_pulse = -1;   // edge index of the next expected report, -1 = none
    int en_edge  = 0;
    int seen_cyc = 0;
    int pat_hi   = 2;
    int pat_lo   = 2;
    bit hist [HMAX];      // meas_in as seen by the sync chain (0 while in reset)

    // Reference model state: last reported values for each instance.
    int m_cnt = 0, m_inr = 0, m_ovf = 0, m_lock = 0, m_strk = 0;
    int m4_cnt = 0, m4_inr = 0, m4_ovf = 0, m4_lock = 0, m4_strk = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_range(input string name, input longint act, input longint lo,
                               input longint hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    endtask

    // A rise counted at edge j comes from samples taken at edges j-3 (low) and j-2 (high);
    // the report at edge t covers gate edges t-100 .. t-1.
    task automatic model_report(input int t);
        int s;
        s = 0;
        for (int j = t - GATE_N; j < t; j++)
            if (hist[j-2] && !hist[j-3]) s++;
        m_ovf  = (s > 255) ? 1 : 0;
        m_cnt  = m_ovf ? 255 : s;
        m_inr  = (!m_ovf && m_cnt >= EMIN && m_cnt <= EMAX) ? 1 : 0;
        m_strk = m_inr ? ((m_strk < LOCKW) ? m_strk + 1 : LOCKW) : 0;
        m_lock = (m_strk >= LOCKW) ? 1 : 0;
        m4_ovf  = (s > 15) ? 1 : 0;
        m4_cnt  = m4_ovf ? 15 : s;
        m4_inr  = (!m4_ovf && m4_cnt >= EMIN && m4_cnt <= EMAX) ? 1 : 0;
        m4_strk = m4_inr ? ((m4_strk < LOCKW) ? m4_strk + 1 : LOCKW) : 0;
        m4_lock = (m4_strk >= LOCKW) ? 1 : 0;
    endtask

    // meas_in pattern generator: pat_hi cycles high, pat_lo low; 0 in either holds constant.
    initial begin
        int ph;
        ph = 0;
        meas_in = 1'b0;
        forever begin
            @(negedge inclk0);
            if (pat_lo == 0)      meas_in = 1'b1;
            else if (pat_hi == 0) meas_in = 1'b0;
            else begin
                ph = (ph + 1) % (pat_hi + pat_lo);
                meas_in = (ph < pat_hi);
            end
        end
    end

    // Per-cycle scoreboard, sampled 1 ns after each rising edge.
    always begin
        logic pulse_due;
        @(posedge inclk0);
        cyc = cyc + 1;
        if (cyc < HMAX) hist[cyc] = rst_n && meas_in;
        #1;
        pulse_due = (exp_pulse >= 0) && (cyc == exp_pulse);
        if (pulse_due) begin
            model_report(cyc);
            exp_pulse = exp_pulse + PERIOD;
        end
        check("count_valid", count_valid, pulse_due);
        check("count", count, m_cnt);
        check("in_range", in_range, m_inr);
        check("overflow", overflow, m_ovf);
        check("locked", locked, m_lock);
        check("count_valid4", count_valid4, pulse_due);
        check("count4", count4, m4_cnt);
        check("in_range4", in_range4, m4_inr);
        check("overflow4", overflow4, m4_ovf);
        check("locked4", locked4, m4_lock);
    end

    task automatic wait_pulses(input int n);
        int got, budget;
        got = 0;
        budget = n * PERIOD + 10;
        while (got < n && budget > 0) begin
            @(negedge inclk0);
            budget--;
            if (count_valid) begin
                got++;
                seen_cyc = cyc;
            end
        end
        check("pulse_wait", got, n);
    endtask

    task automatic start_enable();
        enable    = 1'b1;
        en_edge   = cyc + 1;
        exp_pulse = cyc + 1 + PERIOD;
    endtask

    task automatic abort_enable();
        enable    = 1'b0;
        exp_pulse = -1;
        m_strk = 0; m_lock = 0; m4_strk = 0; m4_lock = 0;
    endtask

    task automatic assert_reset();
        rst_n     = 1'b0;
        exp_pulse = -1;
        m_cnt = 0; m_inr = 0; m_ovf = 0; m_lock = 0; m_strk = 0;
        m4_cnt = 0; m4_inr = 0; m4_ovf = 0; m4_lock = 0; m4_strk = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_cv"}, count_valid, 0);
        check({tag, "_in_range"}, in_range, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_locked"}, locked, 0);
    endtask

    typedef struct {
        int hi;
        int lo;
        int cmin;
        int cmax;
        int inr;
        int ovf4;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        int t1;
        vecs[0] = '{0, 1, 0, 0, 0, 0};     // held low
        vecs[1] = '{1, 0, 0, 0, 0, 0};     // held high
        vecs[2] = '{2, 2, 25, 25, 1, 1};   // period 4
        vecs[3] = '{2, 3, 20, 20, 0, 1};   // period 5
        vecs[4] = '{1, 3, 25, 25, 1, 1};   // period 4, 25% duty
        vecs[5] = '{2, 1, 33, 34, 0, 1};   // period 3
        vecs[6] = '{3, 5, 12, 13, 0, 0};   // period 8
        vecs[7] = '{2, 4, 16, 17, 0, 1};   // period 6
        vecs[8] = '{3, 1, 25, 25, 1, 1};   // period 4, 75% duty
        vecs[9] = '{4, 4, 12, 13, 0, 0};   // period 8 again

        // Reset with meas_in toggling.
        assert_reset();
        enable = 1'b0;
        repeat (3) @(negedge inclk0);
        check_zero("rst_hold");
        repeat (2) @(negedge inclk0);
        rst_n = 1'b1;
        @(negedge inclk0);
        check_zero("rst_after");

        // Period 4: 25 edges, 101-cycle spacing, lock on the third report.
        start_enable();
        wait_pulses(1);
        check("s2_first_latency", seen_cyc - en_edge, PERIOD);
        check("s2_inr1", in_range, 1);
        check("s2_lock1", locked, 0);
        t1 = seen_cyc;
        wait_pulses(1);
        check("s2_spacing", seen_cyc - t1, PERIOD);
        check("s2_count", count, 25);
        check("s2_lock2", locked, 0);
        wait_pulses(1);
        check("s2_lock3", locked, 1);
        check("s5_count4", count4, 15);
        check("s5_ovf4", overflow4, 1);
        check("s5_inr4", in_range4, 0);
        check("s5_lock4", locked4, 0);

        // Slow down to period 8 while locked, then return to period 4.
        pat_hi = 4; pat_lo = 4;
        wait_pulses(1);
        check("s3_inr", in_range, 0);
        check("s3_unlock", locked, 0);
        wait_pulses(1);
        check_range("s3_count8", count, 12, 13);
        pat_hi = 2; pat_lo = 2;
        wait_pulses(1);
        wait_pulses(3);
        check("s3_relock", locked, 1);

        // Table of steady patterns: first report after a change is mixed, check the second.
        for (int i = 0; i < 10; i++) begin
            pat_hi = vecs[i].hi;
            pat_lo = vecs[i].lo;
            wait_pulses(2);
            check_range("tbl_count", count, vecs[i].cmin, vecs[i].cmax);
            check("tbl_in_range", in_range, vecs[i].inr);
            check("tbl_overflow", overflow, 0);
            check_range("tbl_count4", count4, (vecs[i].cmin > 15) ? 15 : vecs[i].cmin,
                        (vecs[i].cmax > 15) ? 15 : vecs[i].cmax);
            check("tbl_overflow4", overflow4, vecs[i].ovf4);
        end

        // Random pattern changes at random times, with occasional aborts.
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(20, 200)) @(negedge inclk0);
            if ($urandom_range(0, 5) == 0) begin
                pat_hi = $urandom_range(0, 1);
                pat_lo = 1 - pat_hi;
            end else begin
                pat_hi = $urandom_range(1, 4);
                pat_lo = $urandom_range(2, 4);
            end
            if ($urandom_range(0, 3) == 0) begin
                if (cyc + 1 == exp_pulse) @(negedge inclk0);
                abort_enable();
                repeat ($urandom_range(1, 20)) @(negedge inclk0);
                start_enable();
            end
        end

        // Abort at gate cycle 50 while locked.
        pat_hi = 2; pat_lo = 2;
        wait_pulses(4);
        check("s6_locked", locked, 1);
        repeat (50) @(negedge inclk0);
        abort_enable();
        repeat (150) @(negedge inclk0);
        check("s6_abort_unlock", locked, 0);
        check("s6_abort_count", count, 25);
        start_enable();
        wait_pulses(1);
        check("s6_reenable_latency", seen_cyc - en_edge, PERIOD);
        check("s6_reenable_count", count, 25);

        // Abort sampled in the final gate cycle: abort wins, no report.
        repeat (99) @(negedge inclk0);
        abort_enable();
        repeat (20) @(negedge inclk0);
        check("s6_lastgate_cv", count_valid, 0);
        check("s6_lastgate_hold", count, 25);

        // Reset in the middle of a window with enable held high.
        start_enable();
        repeat (40) @(negedge inclk0);
        assert_reset();
        repeat (3) @(negedge inclk0);
        check_zero("s6_rst");
        rst_n     = 1'b1;
        en_edge   = cyc + 1;
        exp_pulse = cyc + 1 + PERIOD;
        wait_pulses(1);
        check("s6_rst_latency", seen_cyc - en_edge, PERIOD);
        wait_pulses(1);
        check("s6_rst_count", count, 25);

        repeat (5) @(negedge inclk0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
